uart_port_responder: RTL and testbench



---
 rtl/uart_port_responder.sv | 178 +++++++++++++++++
 tb/tb_uart_port_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_responder.sv
// uart_port_responder: device end of the CPU/UART strobe handshake with 8N1 tx/rx.
// Define FRAMING_ERR_EN to add a sticky frame_err flag cleared by the next read.
module uart_port_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] bus_data,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
`ifdef FRAMING_ERR_EN
    output logic       frame_err,
`endif
    input  logic       rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [7:0]    thr_q, thr_d, tsr_q, tsr_d, rsr_q, rsr_d, rbr_q, rbr_d;
    logic          tbre_q, tbre_d, tsre_q, tsre_d, data_ready_q, data_ready_d, txd_q, txd_d;
    logic          rdn_q, wrn_q;
    logic [1:0]    sync_q;
    logic          wr_ev, rd_end, rx_s, rx_ok;

    assign wr_ev      = wrn_q & ~wrn;
    assign rd_end     = ~rdn_q & rdn;
    assign rx_s       = sync_q[1];
    assign bus_data   = (!rdn && wrn) ? rbr_q : 'z;
    assign data_ready = data_ready_q;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        thr_d      = thr_q;
        tsr_d      = tsr_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        if (wr_ev && tbre_q) begin
            thr_d  = bus_data;
            tbre_d = 1'b0;
        end
        case (tx_state_q)
            IDLE: if (!tbre_q) begin
                tsr_d      = thr_q;
                tbre_d     = 1'b1;
                tsre_d     = 1'b0;
                tx_cnt_d   = '0;
                tx_state_d = START;
            end
            default: begin
                tx_cnt_d = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + 1'b1;
                if (tx_cnt_q == LAST) begin
                    if (tx_state_q == START) begin
                        tx_idx_d   = 3'd0;
                        tx_state_d = DATA;
                    end else if (tx_state_q == DATA) begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_state_d = (tx_idx_q == 3'd7) ? STOP : DATA;
                    end else if (!tbre_q) begin
                        // back-to-back reload skips the idle bit
                        tsr_d      = thr_q;
                        tbre_d     = 1'b1;
                        tx_state_d = START;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = IDLE;
                    end
                end
            end
        endcase
        txd_d = (tx_state_d == START) ? 1'b0 : (tx_state_d == DATA) ? tsr_d[tx_idx_d] : 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rsr_d      = rsr_q;
        rx_ok      = 1'b0;
        case (rx_state_q)
            IDLE: if (!rx_s) begin
                rx_cnt_d   = '0;
                rx_state_d = START;
            end
            START: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = 3'd0;
                    rx_state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                rx_cnt_d = (rx_cnt_q == LAST) ? '0 : rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST) begin
                    rsr_d      = {rx_s, rsr_q[7:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    rx_state_d = (rx_idx_q == 3'd7) ? STOP : DATA;
                end
            end
            default: begin
                rx_cnt_d = (rx_cnt_q == LAST) ? '0 : rx_cnt_q + 1'b1;
                if (rx_cnt_q == LAST) begin
                    rx_ok      = rx_s;
                    rx_state_d = IDLE;
                end
            end
        endcase
        rbr_d        = rx_ok ? rsr_q : rbr_q;
        data_ready_d = rx_ok | (data_ready_q & ~rd_end);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_q   <= IDLE;
            rx_state_q   <= IDLE;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            rx_idx_q     <= '0;
            thr_q        <= '0;
            tsr_q        <= '0;
            rsr_q        <= '0;
            rbr_q        <= '0;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            data_ready_q <= 1'b0;
            txd_q        <= 1'b1;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            sync_q       <= 2'b11;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            rx_idx_q     <= rx_idx_d;
            thr_q        <= thr_d;
            tsr_q        <= tsr_d;
            rsr_q        <= rsr_d;
            rbr_q        <= rbr_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            data_ready_q <= data_ready_d;
            txd_q        <= txd_d;
            rdn_q        <= rdn;
            wrn_q        <= wrn;
            sync_q       <= {sync_q[0], rxd};
        end
    end

`ifdef FRAMING_ERR_EN
    logic frame_err_q, frame_err_d;
    assign frame_err = frame_err_q;
    always_comb begin
        frame_err_d = ((rx_state_q == STOP) && (rx_cnt_q == LAST) && !rx_s) | (frame_err_q & ~rd_end);
    end
    always_ff @(posedge CLK) begin
        if (RST) frame_err_q <= 1'b0;
        else     frame_err_q <= frame_err_d;
    end
`endif
endmodule

// File: tb/tb_uart_port_responder.sv
// tb_uart_port_responder: directed stimulus with queued expectations for tx frames and bus reads.
module tb_uart_port_responder;
    localparam int N = 4;

    logic CLK = 1'b0, RST = 1'b1, rdn = 1'b1, wrn = 1'b1, rxd = 1'b1;
    logic [7:0] drv = 8'h00;
    logic oe = 1'b0;
    wire  [7:0] bus_data;
    logic data_ready, tbre, tsre, txd;
`ifdef FRAMING_ERR_EN
    logic frame_err;
`endif

    assign bus_data = oe ? drv : 'z;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    uart_port_responder #(.CLKS_PER_BIT(N)) dut (
        .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .bus_data(bus_data),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd),
`ifdef FRAMING_ERR_EN
        .frame_err(frame_err),
`endif
        .rxd(rxd)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] tx_q[$], rd_q[$];
    int starts[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        drv = b; oe = 1'b1; wrn = 1'b0;
        tick; tick;
        wrn = 1'b1; oe = 1'b0;
        tick;
    endtask

    task automatic rd(input logic [7:0] e);
        rd_q.push_back(e);
        rdn = 1'b0;
        tick; tick;
        rdn = 1'b1;
        tick;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = f[k];
            repeat (N) tick;
        end
        rxd = 1'b1;
        repeat (2 * N) tick;
    endtask

    task automatic wait_tsre(input string n);
        for (int i = 0; i < 600 && !tsre; i++) tick;
        chk(n, tsre, 1);
    endtask

    // serial line monitor: samples each bit at its middle and scores the decoded byte
    initial begin
        int mc, k;
        logic [7:0] sh;
        bit busy;
        busy = 0; mc = 0; sh = 8'h00;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) busy = 0;
            else if (!busy) begin
                if (!txd) begin
                    busy = 1; mc = 0;
                    starts.push_back(cyc);
                end
            end else begin
                mc++;
                if (mc % N == N / 2) begin
                    k = mc / N;
                    if (k == 0) chk("tx_start_bit", txd, 0);
                    else if (k <= 8) sh[k-1] = txd;
                    else begin
                        chk("tx_stop_bit", txd, 1);
                        chk("tx_frame_expected", 32'(tx_q.size() > 0), 1);
                        if (tx_q.size() > 0) chk("tx_byte", sh, tx_q.pop_front());
                        busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (!rdn && wrn && prev) begin
                chk("rd_expected", 32'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) chk("rd_data", bus_data, rd_q.pop_front());
            end
            prev = rdn;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp1;
        exp1 = 10'b1101001010;
        repeat (3) tick;
        chk("rst_tbre", tbre, 1);
        chk("rst_tsre", tsre, 1);
        chk("rst_dr", data_ready, 0);
        chk("rst_txd", txd, 1);
        chk("rst_bus", bus_data, 8'hFF);
        RST = 1'b0;
        tick;

        tx_q.push_back(8'hA5);
        drv = 8'hA5; oe = 1'b1; wrn = 1'b0;
        tick;
        chk("t1_tbre_low", tbre, 0);
        chk("t1_tsre_idle", tsre, 1);
        tick;
        chk("t1_tbre_back", tbre, 1);
        chk("t1_tsre_busy", tsre, 0);
        wrn = 1'b1; oe = 1'b0;
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < N; c++) begin
                chk($sformatf("t1_txd_b%0d", k), txd, exp1[k]);
                tick;
            end
        chk("t1_tsre_end", tsre, 1);
        chk("t1_txd_end", txd, 1);

        starts.delete();
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h80);
        wr(8'h01);
        wr(8'h80);
        chk("t2_thr_accepted", tbre, 0);
        wr(8'hFF);
        chk("t2_drop_tbre", tbre, 0);
        wait_tsre("t2_done");
        chk("t2_frames", starts.size(), 2);
        if (starts.size() == 2) chk("t2_back_to_back", starts[1] - starts[0], 10 * N);
        chk("t2_tx_drained", tx_q.size(), 0);

        send_rx(8'h3C, 1'b1);
        chk("t3_dr_set", data_ready, 1);
        chk("t3_bus_idle", bus_data, 8'hFF);
        rd(8'h3C);
        chk("t3_dr_clear", data_ready, 0);
        chk("t3_bus_released", bus_data, 8'hFF);

        rxd = 1'b0;
        tick;
        rxd = 1'b1;
        repeat (3 * N) tick;
        chk("t4_glitch_dr", data_ready, 0);
        send_rx(8'h55, 1'b0);
        chk("t4_ferr_dr", data_ready, 0);
`ifdef FRAMING_ERR_EN
        chk("t4_frame_err_set", frame_err, 1);
        rd(8'h3C);
        chk("t4_frame_err_clr", frame_err, 0);
`endif

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        chk("t5_dr_overrun", data_ready, 1);
        rd(8'h22);
        chk("t5_dr_clear", data_ready, 0);

        send_rx(8'h44, 1'b1);
        chk("t6_pre_dr", data_ready, 1);
        wr(8'h70);
        rxd = 1'b0;
        repeat (6) tick;
        chk("t6_pre_txd", txd, 0);
        chk("t6_pre_tsre", tsre, 0);
        RST = 1'b1;
        tick;
        chk("t6_rst_txd", txd, 1);
        chk("t6_rst_tbre", tbre, 1);
        chk("t6_rst_tsre", tsre, 1);
        chk("t6_rst_dr", data_ready, 0);
        RST = 1'b0;
        rxd = 1'b1;
        repeat (4 * N) tick;
        chk("t6_post_dr", data_ready, 0);
        tx_q.push_back(8'h5A);
        wr(8'h5A);
        wait_tsre("t6_done");
        repeat (2) tick;

        chk("tx_q_drained", tx_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
